// File: rtl/spi_multi_sequence_detector.sv
// Passive SPI sniffer: compares the sampled bit stream against NUM_KEYS fixed keys
// in any SPI mode, MSB- or LSB-first, and pulses match with the lowest matching key index.
module spi_multi_sequence_detector #(
  parameter int KEY_SIZE = 64,
  parameter int NUM_KEYS = 2,
  parameter logic [NUM_KEYS*KEY_SIZE-1:0] KEYS = {64'hA5A55A5AC3C33C3C, 64'h929d9a9b2935a265},
  parameter int COUNT_WIDTH = 16,
  localparam int ID_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CNT_W = $clog2(KEY_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   sin,
  input  logic                   cs_n,
  input  logic [1:0]             mode,
  input  logic                   lsb_first,
  input  logic                   count_clear,
  output logic                   match,
  output logic [ID_W-1:0]        match_id,
  output logic [NUM_KEYS-1:0]    match_vec,
  output logic [COUNT_WIDTH-1:0] match_count
);

  logic                sclk_prev_q;
  logic                armed_q;
  logic                active_q;
  logic [1:0]          mode_l_q;
  logic                lsb_l_q;
  logic [KEY_SIZE-1:0] shift_q;
  logic [CNT_W-1:0]    bit_cnt_q;

  logic                lead_edge;
  logic                trail_edge;
  logic                sample_edge;
  logic                full;
  logic [CNT_W:0]      cnt_inc;
  logic [KEY_SIZE-1:0] shift_d;
  logic [KEY_SIZE-1:0] key;
  logic [NUM_KEYS-1:0] hit;
  logic [ID_W-1:0]     hit_id;

  function automatic logic [KEY_SIZE-1:0] bit_rev(input logic [KEY_SIZE-1:0] v);
    logic [KEY_SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < KEY_SIZE; b++) r[b] = v[KEY_SIZE-1-b];
    return r;
  endfunction

  always_comb begin
    lead_edge   = (sclk_prev_q == mode_l_q[1]) && (sclk != mode_l_q[1]);
    trail_edge  = (sclk_prev_q != mode_l_q[1]) && (sclk == mode_l_q[1]);
    // active_q is low on the cs_n-fall cycle and after reset until a fresh fall.
    sample_edge = !cs_n && active_q && (mode_l_q[0] ? trail_edge : lead_edge);
    shift_d     = lsb_l_q ? {sin, shift_q[KEY_SIZE-1:1]} : {shift_q[KEY_SIZE-2:0], sin};
    cnt_inc     = {1'b0, bit_cnt_q} + (CNT_W+1)'(1);
    full        = cnt_inc >= (CNT_W+1)'(KEY_SIZE);
    key         = '0;
    hit         = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key    = KEYS[i*KEY_SIZE +: KEY_SIZE];
      hit[i] = full && (shift_d == (lsb_l_q ? bit_rev(key) : key));
    end
    hit_id = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hit[i]) hit_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      active_q    <= 1'b0;
      mode_l_q    <= 2'b00;
      lsb_l_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      match       <= 1'b0;
      match_id    <= '0;
      match_vec   <= '0;
      match_count <= '0;
    end else begin
      sclk_prev_q <= sclk;
      armed_q     <= cs_n;
      active_q    <= !cs_n && (active_q || armed_q);
      if (cs_n) begin
        mode_l_q  <= mode;
        lsb_l_q   <= lsb_first;
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (sample_edge) begin
        shift_q <= shift_d;
        if (bit_cnt_q != CNT_W'(KEY_SIZE)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      match     <= sample_edge && (|hit);
      match_vec <= sample_edge ? hit : '0;
      if (sample_edge && (|hit)) match_id <= hit_id;
      if (count_clear) match_count <= '0;
      else if (match && !(&match_count)) match_count <= match_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_spi_multi_sequence_detector.sv
// Bench for spi_multi_sequence_detector: three instances (default, repeated-key, 2-bit counter)
// share one sniffed SPI stream; a wire-order window model predicts every match and count.
module tb_spi_multi_sequence_detector;

  localparam logic [63:0] KEY0 = 64'h929d9a9b2935a265;
  localparam logic [63:0] KEY1 = 64'hA5A55A5AC3C33C3C;
  localparam logic [63:0] KREP = 64'h0F0F0F0F0F0F0F0F;

  logic clk = 1'b0;
  logic rst, sclk, sin, cs_n, lsb_first, count_clear;
  logic [1:0] mode;

  logic        m_match, m_id;
  logic [1:0]  m_vec;
  logic [15:0] m_cnt;
  logic        r_match, r_id;
  logic [1:0]  r_vec;
  logic [15:0] r_cnt;
  logic        s_match, s_id;
  logic [1:0]  s_vec;
  logic [1:0]  s_cnt;

  spi_multi_sequence_detector dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .cs_n(cs_n), .mode(mode),
    .lsb_first(lsb_first), .count_clear(count_clear), .match(m_match),
    .match_id(m_id), .match_vec(m_vec), .match_count(m_cnt));

  spi_multi_sequence_detector #(.KEYS({KREP, KREP})) dut_rep (
    .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .cs_n(cs_n), .mode(mode),
    .lsb_first(lsb_first), .count_clear(count_clear), .match(r_match),
    .match_id(r_id), .match_vec(r_vec), .match_count(r_cnt));

  spi_multi_sequence_detector #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .cs_n(cs_n), .mode(mode),
    .lsb_first(lsb_first), .count_clear(count_clear), .match(s_match),
    .match_id(s_id), .match_vec(s_vec), .match_count(s_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last 64 wire bits of the current frame, oldest first.
  bit         wire_q[$];
  bit         frame_on;
  logic [1:0] cur_mode;
  logic       exp_id_m, exp_id_r;
  int         exp_cnt_m, exp_cnt_r, exp_cnt_s;
  logic [47:0] obs_pack, exp_pack;
  logic        last_r_match;

  function automatic logic [1:0] model_hits(input logic [63:0] k0, input logic [63:0] k1);
    logic [1:0]  h;
    logic [63:0] kk;
    int          n;
    h = 2'b00;
    n = wire_q.size();
    if (frame_on && n >= 64) begin
      for (int k = 0; k < 2; k++) begin
        kk = (k == 0) ? k0 : k1;
        h[k] = 1'b1;
        for (int j = 0; j < 64; j++) if (wire_q[n-64+j] != kk[63-j]) h[k] = 1'b0;
      end
    end
    return h;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Drives one bit with the waveform of cur_mode, records observations and model expectations.
  task automatic step(input bit b, input bit clr);
    bit cpol, cpha;
    logic [1:0] hm, hr;
    logic o_m1, o_m2, o_m3;
    logic [1:0] o_mv, o_rv, o_sv;
    logic o_mi, o_ri, o_si, o_r1, o_s1;
    cpol = cur_mode[1];
    cpha = cur_mode[0];
    if (!cpha) begin
      sin = b;
      @(negedge clk);
      sclk = ~cpol;
    end else begin
      sclk = ~cpol;
      @(negedge clk);
      sin = b;
      @(negedge clk);
      sclk = cpol;
    end
    if (frame_on) begin
      wire_q.push_back(b);
      if (wire_q.size() > 64) void'(wire_q.pop_front());
    end
    hm = model_hits(KEY0, KEY1);
    hr = model_hits(KREP, KREP);
    if (|hm) exp_id_m = hm[0] ? 1'b0 : 1'b1;
    if (|hr) exp_id_r = hr[0] ? 1'b0 : 1'b1;
    count_clear = clr;
    @(negedge clk);
    o_m1 = m_match; o_mv = m_vec; o_mi = m_id;
    o_r1 = r_match; o_rv = r_vec; o_ri = r_id;
    o_s1 = s_match; o_sv = s_vec; o_si = s_id;
    last_r_match = r_match;
    @(negedge clk);
    count_clear = 1'b0;
    o_m2 = m_match | r_match | s_match;
    exp_cnt_m = clr ? 0 : ((|hm) ? sat_inc(exp_cnt_m, 65535) : exp_cnt_m);
    exp_cnt_r = clr ? 0 : ((|hr) ? sat_inc(exp_cnt_r, 65535) : exp_cnt_r);
    exp_cnt_s = clr ? 0 : ((|hm) ? sat_inc(exp_cnt_s, 3) : exp_cnt_s);
    obs_pack = {o_m1, o_mv, o_mi, o_r1, o_rv, o_ri, o_s1, o_sv, o_si, o_m2, 1'b0,
                m_cnt, r_cnt, s_cnt};
    if (!cpha) sclk = cpol;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    o_m3 = m_match | r_match | s_match;
    obs_pack[32] = o_m3;
    exp_pack = {|hm, hm, exp_id_m, |hr, hr, exp_id_r, |hm, hm, exp_id_m, 1'b0, 1'b0,
                16'(exp_cnt_m), 16'(exp_cnt_r), 2'(exp_cnt_s)};
  endtask

  task automatic start_frame(input logic [1:0] md, input bit lsb);
    cs_n = 1'b1;
    frame_on = 1'b0;
    wire_q.delete();
    repeat (2) @(negedge clk);
    mode = md;
    lsb_first = lsb;
    cur_mode = md;
    sclk = md[1];
    repeat (3) @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    frame_on = 1'b1;
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    frame_on = 1'b0;
    wire_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic model_reset();
    frame_on = 1'b0;
    wire_q.delete();
    exp_id_m = 1'b0; exp_id_r = 1'b0;
    exp_cnt_m = 0; exp_cnt_r = 0; exp_cnt_s = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mode = 2'b00; lsb_first = 1'b0;
    count_clear = 1'b0; cur_mode = 2'b00;
    repeat (3) begin
      @(negedge clk);
      sin = 1'($urandom);
    end
    checks++;
    if ({m_match, m_id, m_vec, m_cnt, r_match, r_vec, r_cnt, s_match, s_vec, s_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got m=%b id=%b vec=%b cnt=%0d, expected all zero",
               m_match, m_id, m_vec, m_cnt);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_mode0_msb();
    start_frame(2'b00, 1'b0);
    for (int i = 63; i >= 0; i--) begin
      step(KEY0[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL mode0_msb[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    checks++;
    if (m_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mode0_count: got %0d, expected 1", m_cnt);
    end
    end_frame();
  endtask

  task automatic test_mode3_lsb();
    start_frame(2'b11, 1'b1);
    for (int i = 63; i >= 0; i--) begin
      step(KEY1[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL mode3_lsb[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    end_frame();
  endtask

  task automatic test_frame_gating();
    start_frame(2'b00, 1'b0);
    for (int i = 63; i >= 1; i--) step(KEY0[i], 1'b0);
    cs_n = 1'b1;
    frame_on = 1'b0;
    wire_q.delete();
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    frame_on = 1'b1;
    step(KEY0[0], 1'b0);
    checks++;
    if (obs_pack !== exp_pack) begin
      errors++;
      $display("FAIL gating_first_bit: got %h, expected %h", obs_pack, exp_pack);
    end
    for (int i = 63; i >= 0; i--) begin
      step(KEY0[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL gating_refill[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    // Last key bit sampled on the same cycle cs_n rises: must be dropped.
    for (int i = 63; i >= 1; i--) step(KEY1[i], 1'b0);
    sin = KEY1[0];
    @(negedge clk);
    sclk = 1'b1;
    cs_n = 1'b1;
    frame_on = 1'b0;
    wire_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (m_match !== 1'b0) begin
        errors++;
        $display("FAIL cs_rise_edge[%0d]: got match=%b, expected 0", k, m_match);
      end
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode_change();
    start_frame(2'b00, 1'b0);
    for (int i = 63; i >= 0; i--) begin
      if (i == 33) mode = 2'b10;
      step(KEY0[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL mode_hold[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    end_frame();
    start_frame(2'b10, 1'b0);
    for (int i = 63; i >= 0; i--) begin
      step(KEY1[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL mode2_frame[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    end_frame();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    start_frame(2'b01, 1'b0);
    for (int i = 0; i < 72; i++) begin
      step(KREP[63 - (i % 8)], 1'b0);
      if (last_r_match === 1'b1) pulses++;
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL periodic[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL periodic_pulses: got %0d, expected 2", pulses);
    end
    end_frame();
  endtask

  task automatic test_saturation();
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    exp_cnt_m = 0; exp_cnt_r = 0; exp_cnt_s = 0;
    @(negedge clk);
    start_frame(2'b00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 63; i >= 0; i--) begin
        step(KEY0[i], (k == 5) && (i == 0));
        checks++;
        if (obs_pack !== exp_pack) begin
          errors++;
          $display("FAIL saturate[%0d.%0d]: got %h, expected %h", k, i, obs_pack, exp_pack);
        end
      end
      if (k == 4) begin
        checks++;
        if (s_cnt !== 2'd3) begin
          errors++;
          $display("FAIL sat_count: got %0d, expected 3", s_cnt);
        end
      end
    end
    checks++;
    if (s_cnt !== 2'd0 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_on_match: got s=%0d m=%0d, expected 0", s_cnt, m_cnt);
    end
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    start_frame(2'b01, 1'b0);
    for (int i = 63; i >= 24; i--) step(KEY0[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 23; i >= 0; i--) begin
      step(KEY0[i], 1'b0);
      checks++;
      if (obs_pack !== exp_pack) begin
        errors++;
        $display("FAIL reset_mid_frame[%0d]: got %h, expected %h", i, obs_pack, exp_pack);
      end
    end
    end_frame();
  endtask

  task automatic test_random();
    bit stream[$];
    logic [63:0] kk;
    for (int f = 0; f < 6; f++) begin
      stream.delete();
      while (stream.size() < $urandom_range(80, 160)) begin
        if ($urandom_range(0, 29) == 0) begin
          kk = $urandom_range(0, 1) ? KEY1 : ($urandom_range(0, 1) ? KEY0 : KREP);
          for (int i = 63; i >= 0; i--) stream.push_back(kk[i]);
        end else begin
          stream.push_back(1'($urandom));
        end
      end
      start_frame(2'($urandom), 1'($urandom));
      foreach (stream[i]) begin
        step(stream[i], 1'b0);
        checks++;
        if (obs_pack !== exp_pack) begin
          errors++;
          $display("FAIL random[%0d.%0d]: got %h, expected %h", f, i, obs_pack, exp_pack);
        end
      end
      end_frame();
    end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_frame_gating();
    test_mode_change();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
